// File: rtl/jtag_bitbang_master.sv
// jtag_bitbang_master: OpenOCD remote_bitbang byte stream to paced JTAG pins, TDO replies via FIFO
module jtag_bitbang_master #(
    parameter int HOLD_CYCLES = 4,
    parameter int RSP_DEPTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       jtag_tck_o,
    output logic       jtag_tms_o,
    output logic       jtag_tdi_o,
    input  logic       jtag_tdo_i,
    output logic       jtag_trst_n_o,
    output logic       jtag_srst_n_o,
    output logic       blink_o,
    output logic       quit_o,
    output logic [7:0] bad_cmd_cnt_o
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic                   trst_q, trst_d, srst_q, srst_d;
    logic                   blink_q, blink_d, quit_q, quit_d;
    logic [7:0]             bad_q, bad_d;
    logic [7:0]             mem_q [RSP_DEPTH];
    logic [7:0]             mem_d [RSP_DEPTH];
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   accept, push, pop, pin_cmd, rst_cmd;
    logic [1:0]             k;

    // Ready looks only at the registered count, so a full FIFO stalls 'R' one cycle past a pop
    assign cmd_ready_o   = state_q == IDLE && cnt_q != CW'(RSP_DEPTH);
    assign rsp_valid_o   = cnt_q != '0;
    assign rsp_data_o    = mem_q[rd_q];
    assign jtag_tck_o    = tck_q;
    assign jtag_tms_o    = tms_q;
    assign jtag_tdi_o    = tdi_q;
    assign jtag_trst_n_o = trst_q;
    assign jtag_srst_n_o = srst_q;
    assign blink_o       = blink_q;
    assign quit_o        = quit_q;
    assign bad_cmd_cnt_o = bad_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sync_d  = SYNC_STAGES'({sync_q, jtag_tdo_i});
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = trst_q;
        srst_d  = srst_q;
        blink_d = blink_q;
        quit_d  = quit_q;
        bad_d   = bad_q;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pin_cmd = cmd_data_i[7:3] == 5'b00110;
        rst_cmd = cmd_data_i >= 8'h72 && cmd_data_i <= 8'h75;
        k       = 2'(cmd_data_i - 8'h72);
        accept  = cmd_valid_i && cmd_ready_o;
        push    = accept && cmd_data_i == 8'h52;
        pop     = rsp_valid_o && rsp_ready_i;
        // Leaving on the count of 1 makes accept-to-accept spacing exactly HOLD_CYCLES
        if (state_q == HOLD) begin
            hold_d  = hold_q - HW'(1);
            state_d = hold_q <= HW'(1) ? IDLE : HOLD;
        end
        if (accept) begin
            if (pin_cmd || rst_cmd) begin
                hold_d  = HW'(HOLD_CYCLES - 1);
                state_d = HOLD_CYCLES > 1 ? HOLD : IDLE;
            end
            if (pin_cmd) {tck_d, tms_d, tdi_d} = cmd_data_i[2:0];
            else if (rst_cmd) {trst_d, srst_d} = ~k;
            else if (cmd_data_i == 8'h42) blink_d = 1'b1;
            else if (cmd_data_i == 8'h62) blink_d = 1'b0;
            else if (cmd_data_i == 8'h51) quit_d = 1'b1;
            else if (cmd_data_i != 8'h52 && bad_q != 8'hFF) bad_d = bad_q + 8'd1;
        end
        if (push) begin
            mem_d[wr_q] = {7'b0011000, sync_q[SYNC_STAGES-1]};
            wr_d        = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sync_q  <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b0;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b1;
            srst_q  <= 1'b1;
            blink_q <= 1'b0;
            quit_q  <= 1'b0;
            bad_q   <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sync_q  <= sync_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
            srst_q  <= srst_d;
            blink_q <= blink_d;
            quit_q  <= quit_d;
            bad_q   <= bad_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_jtag_bitbang_master.sv
// tb_jtag_bitbang_master: vector table, corner sequences and random traffic against a protocol-level model
module tb_jtag_bitbang_master;
    localparam int HOLD  = 4;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0, rsp_ready = 1'b0, tdo = 1'b0;
    logic       cmd_ready_o, rsp_valid_o, jtag_tck_o, jtag_tms_o, jtag_tdi_o;
    logic       jtag_trst_n_o, jtag_srst_n_o, blink_o, quit_o;
    logic [7:0] rsp_data_o, bad_cmd_cnt_o;

    jtag_bitbang_master #(.HOLD_CYCLES(HOLD), .RSP_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
        .jtag_tdo_i(tdo), .jtag_trst_n_o(jtag_trst_n_o), .jtag_srst_n_o(jtag_srst_n_o),
        .blink_o(blink_o), .quit_o(quit_o), .bad_cmd_cnt_o(bad_cmd_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pin levels, a byte queue for responses, a TDO delay line, and the
    // earliest edge number at which a new command may be taken.
    bit        m_tck, m_tms, m_tdi, m_trst, m_srst, m_blink, m_quit;
    int        m_bad, cyc, next_ok, acc_edge;
    bit        acc;
    bit [7:0]  q[$];
    bit        hist[$];

    function automatic bit m_ready();
        return cyc >= next_ok && q.size() < DEPTH;
    endfunction

    task automatic model_reset();
        {m_tck, m_tms, m_tdi} = 3'b000;
        {m_trst, m_srst} = 2'b11;
        m_blink = 0; m_quit = 0; m_bad = 0; next_ok = 0;
        q.delete();
        hist.delete();
        repeat (SYNC) hist.push_back(1'b0);
    endtask

    task automatic model_cmd(input bit [7:0] b, input bit t);
        bit [7:0] v;
        if (b >= 8'h30 && b <= 8'h37) begin
            v = b - 8'h30;
            {m_tck, m_tms, m_tdi} = v[2:0];
            next_ok = cyc + HOLD;
        end else if (b == 8'h52) q.push_back(8'h30 + {7'd0, t});
        else if (b >= 8'h72 && b <= 8'h75) begin
            v = b - 8'h72;
            m_trst = !v[1];
            m_srst = !v[0];
            next_ok = cyc + HOLD;
        end else if (b == 8'h42) m_blink = 1;
        else if (b == 8'h62) m_blink = 0;
        else if (b == 8'h51) m_quit = 1;
        else if (m_bad < 255) m_bad++;
    endtask

    task automatic compare();
        chk("tck", jtag_tck_o, m_tck);
        chk("tms", jtag_tms_o, m_tms);
        chk("tdi", jtag_tdi_o, m_tdi);
        chk("trst_n", jtag_trst_n_o, m_trst);
        chk("srst_n", jtag_srst_n_o, m_srst);
        chk("blink", blink_o, m_blink);
        chk("quit", quit_o, m_quit);
        chk("bad_cnt", bad_cmd_cnt_o, m_bad);
        chk("rsp_valid", rsp_valid_o, q.size() > 0);
        if (q.size() > 0) chk("rsp_data", rsp_data_o, q[0]);
    endtask

    task automatic tick();
        bit r, t;
        r = m_ready();
        chk("cmd_ready", cmd_ready_o, r);
        @(posedge clk);
        acc = 0;
        if (rst) model_reset();
        else begin
            t = hist.pop_front();
            hist.push_back(tdo);
            if (q.size() > 0 && rsp_ready) void'(q.pop_front());
            if (cmd_valid && r) begin
                acc = 1;
                acc_edge = cyc;
                model_cmd(cmd_data, t);
            end
        end
        cyc++;
        #1 compare();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        cmd_valid = 1;
        cmd_data = b;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 0;
        repeat (n) tick();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [6:0] outs;
        int         bad;
        int         gap;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int prev;
        logic [7:0] lst [19];
        // outs = {tck, tms, tdi, trst_n, srst_n, blink, quit}
        tbl = '{
            '{8'h36, 7'b1101100, 0, 0},
            '{8'h34, 7'b1001100, 0, HOLD},
            '{8'h31, 7'b0011100, 0, HOLD},
            '{8'h74, 7'b0010100, 0, HOLD},
            '{8'h73, 7'b0011000, 0, HOLD},
            '{8'h72, 7'b0011100, 0, HOLD},
            '{8'h42, 7'b0011110, 0, HOLD},
            '{8'h78, 7'b0011110, 1, 1},
            '{8'hFF, 7'b0011110, 2, 1},
            '{8'h51, 7'b0011111, 2, 1},
            '{8'h62, 7'b0011101, 2, 1}
        };
        lst = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h52, 8'h52,
                8'h52, 8'h72, 8'h73, 8'h74, 8'h75, 8'h42, 8'h62, 8'h51, 8'h52};

        repeat (2) @(posedge clk);
        cyc = 0;
        acc_edge = 0;
        model_reset();
        #1 rst = 0;
        chk("rst_tck", jtag_tck_o, 0);
        chk("rst_trst_n", jtag_trst_n_o, 1);
        chk("rst_srst_n", jtag_srst_n_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_bad_cnt", bad_cmd_cnt_o, 0);

        prev = 0;
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].cmd);
            chk($sformatf("vec%0d_pins", i),
                {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_n_o, jtag_srst_n_o, blink_o, quit_o},
                tbl[i].outs);
            chk($sformatf("vec%0d_bad", i), bad_cmd_cnt_o, tbl[i].bad);
            if (i > 0) chk($sformatf("vec%0d_gap", i), acc_edge - prev, tbl[i].gap);
            prev = acc_edge;
        end

        tdo = 1;
        idle(3);
        send(8'h52);
        tdo = 0;
        idle(3);
        send(8'h52);
        idle(1);
        chk("tdo_first", rsp_data_o, 8'h31);
        rsp_ready = 1;
        tick();
        chk("tdo_second", rsp_data_o, 8'h30);
        tick();
        chk("tdo_drained", rsp_valid_o, 0);
        rsp_ready = 0;

        for (int i = 0; i < DEPTH; i++) begin
            tdo = 1'($urandom);
            send(8'h52);
        end
        tick();
        chk("full_stall", cmd_ready_o, 0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("full_freed", cmd_ready_o, 1);
        tick();
        chk("ninth_accept", acc_edge, cyc - 1);
        cmd_valid = 0;
        rsp_ready = 1;
        repeat (DEPTH + 2) tick();
        chk("fill_drained", rsp_valid_o, 0);
        rsp_ready = 0;

        repeat (3) send(8'h52);
        send(8'h51);
        send(8'h37);
        cmd_valid = 0;
        tick();
        chk("pre_rst_valid", rsp_valid_o, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("hold_rst_tck", jtag_tck_o, 0);
        chk("hold_rst_tms", jtag_tms_o, 0);
        chk("hold_rst_tdi", jtag_tdi_o, 0);
        chk("hold_rst_rsp_valid", rsp_valid_o, 0);
        chk("hold_rst_ready", cmd_ready_o, 1);
        chk("hold_rst_quit", quit_o, 0);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = $urandom_range(0, 3) != 0;
            cmd_data = $urandom_range(0, 9) == 0 ? 8'($urandom) : lst[$urandom_range(0, 18)];
            rsp_ready = 1'($urandom);
            tdo = 1'($urandom);
            rst = $urandom_range(0, 299) == 0;
            tick();
            rst = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
